// File: rtl/acc_writeback.sv
// Writeback stage behind the 8-bit ALU: owns accumulators A/B and the carry/zero flags,
// sequences data-memory loads and stores, and counts retired instructions.
module acc_writeback #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iValid,
  output logic        oReady,
  input  logic [5:0]  iOpcode,
  input  logic [8:0]  iAluOut,
  input  logic [7:0]  iConst,
  input  logic [7:0]  iAddr,
  input  logic [7:0]  iMemData,
  input  logic        iMemValid,
  output logic [7:0]  oRegA,
  output logic [7:0]  oRegB,
  output logic        oCarry,
  output logic        oZero,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic [7:0]  oMemAddr,
  output logic [7:0]  oMemWData,
  output logic        oRetire,
  output logic [15:0] oRetired,
  output logic        oError,
  output logic        oState
);

  // Encodings mirror the shared def.v opcode table.
  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADDA  = 6'd1;
  localparam logic [5:0] OP_ADDB  = 6'd2;
  localparam logic [5:0] OP_ADDCA = 6'd3;
  localparam logic [5:0] OP_ADDCB = 6'd4;
  localparam logic [5:0] OP_SUBA  = 6'd5;
  localparam logic [5:0] OP_SUBB  = 6'd6;
  localparam logic [5:0] OP_SUBCA = 6'd7;
  localparam logic [5:0] OP_SUBCB = 6'd8;
  localparam logic [5:0] OP_ASLA  = 6'd9;
  localparam logic [5:0] OP_ASRA  = 6'd10;
  localparam logic [5:0] OP_ANDA  = 6'd11;
  localparam logic [5:0] OP_ANDB  = 6'd12;
  localparam logic [5:0] OP_ANDCA = 6'd13;
  localparam logic [5:0] OP_ANDCB = 6'd14;
  localparam logic [5:0] OP_ORA   = 6'd15;
  localparam logic [5:0] OP_ORB   = 6'd16;
  localparam logic [5:0] OP_ORCA  = 6'd17;
  localparam logic [5:0] OP_ORCB  = 6'd18;
  localparam logic [5:0] OP_LDCA  = 6'd19;
  localparam logic [5:0] OP_LDCB  = 6'd20;
  localparam logic [5:0] OP_LDA   = 6'd21;
  localparam logic [5:0] OP_LDB   = 6'd22;
  localparam logic [5:0] OP_STA   = 6'd23;
  localparam logic [5:0] OP_STB   = 6'd24;

  localparam logic [7:0] TO_LAST = 8'(LOAD_TIMEOUT - 1);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        c_q, c_d, z_q, z_d;
  logic        rdy_q, rdy_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [7:0]  addr_q, addr_d, wdata_q, wdata_d;
  logic        ret_q, ret_d;
  logic [15:0] retired_q, retired_d;
  logic        err_q, err_d;
  logic        ld_b_q, ld_b_d;
  logic        accept;
  logic [7:0]  alu_res;

  // Handshake: an instruction transfers on a rising edge where iValid && oReady;
  // oReady is registered and high only while IDLE, so iValid is a don't-care otherwise.
  assign accept  = iValid && rdy_q;
  assign alu_res = iAluOut[7:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    z_d       = z_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ret_d     = 1'b0;
    err_d     = err_q;
    ld_b_d    = ld_b_q;
    retired_d = retired_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (accept) begin
          ret_d = 1'b1;
          case (iOpcode)
            OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA, OP_ASLA, OP_ASRA: begin
              a_d = alu_res;
              c_d = iAluOut[8];
              z_d = (alu_res == 8'd0);
            end
            OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB: begin
              b_d = alu_res;
              c_d = iAluOut[8];
              z_d = (alu_res == 8'd0);
            end
            OP_ANDA, OP_ANDCA, OP_ORA, OP_ORCA: begin
              a_d = alu_res;
              z_d = (alu_res == 8'd0);
            end
            OP_ANDB, OP_ANDCB, OP_ORB, OP_ORCB: begin
              b_d = alu_res;
              z_d = (alu_res == 8'd0);
            end
            OP_LDCA: begin
              a_d = iConst;
              z_d = (iConst == 8'd0);
            end
            OP_LDCB: begin
              b_d = iConst;
              z_d = (iConst == 8'd0);
            end
            OP_STA, OP_STB: begin
              wr_d    = 1'b1;
              addr_d  = iAddr;
              wdata_d = alu_res;
            end
            OP_LDA, OP_LDB: begin
              // Loads retire later, from WAIT_LOAD.
              ret_d   = 1'b0;
              rd_d    = 1'b1;
              addr_d  = iAddr;
              ld_b_d  = (iOpcode == OP_LDB);
              state_d = WAIT_LOAD;
            end
            default: ;
          endcase
        end
      end
      WAIT_LOAD: begin
        if (iMemValid) begin
          if (ld_b_q) b_d = iMemData;
          else        a_d = iMemData;
          z_d     = (iMemData == 8'd0);
          ret_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          ret_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ret_d) retired_d = retired_q + 16'd1;
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      rdy_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      ret_q     <= 1'b0;
      retired_q <= 16'd0;
      err_q     <= 1'b0;
      ld_b_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      z_q       <= z_d;
      rdy_q     <= rdy_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ret_q     <= ret_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      ld_b_q    <= ld_b_d;
    end
  end

  assign oReady    = rdy_q;
  assign oRegA     = a_q;
  assign oRegB     = b_q;
  assign oCarry    = c_q;
  assign oZero     = z_q;
  assign oMemRead  = rd_q;
  assign oMemWrite = wr_q;
  assign oMemAddr  = addr_q;
  assign oMemWData = wdata_q;
  assign oRetire   = ret_q;
  assign oRetired  = retired_q;
  assign oError    = err_q;
  assign oState    = state_q;

endmodule

// File: tb/tb_acc_writeback.sv
// Bench for acc_writeback: directed scenarios plus randomized instruction streams,
// compared against an instruction-level reference model and a store scoreboard.
module tb_acc_writeback;

  localparam int LOAD_TIMEOUT = 16;

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADDA  = 6'd1;
  localparam logic [5:0] OP_ADDB  = 6'd2;
  localparam logic [5:0] OP_ADDCA = 6'd3;
  localparam logic [5:0] OP_ADDCB = 6'd4;
  localparam logic [5:0] OP_SUBA  = 6'd5;
  localparam logic [5:0] OP_SUBB  = 6'd6;
  localparam logic [5:0] OP_SUBCA = 6'd7;
  localparam logic [5:0] OP_SUBCB = 6'd8;
  localparam logic [5:0] OP_ASLA  = 6'd9;
  localparam logic [5:0] OP_ASRA  = 6'd10;
  localparam logic [5:0] OP_ANDA  = 6'd11;
  localparam logic [5:0] OP_ANDB  = 6'd12;
  localparam logic [5:0] OP_ANDCA = 6'd13;
  localparam logic [5:0] OP_ANDCB = 6'd14;
  localparam logic [5:0] OP_ORA   = 6'd15;
  localparam logic [5:0] OP_ORB   = 6'd16;
  localparam logic [5:0] OP_ORCA  = 6'd17;
  localparam logic [5:0] OP_ORCB  = 6'd18;
  localparam logic [5:0] OP_LDCA  = 6'd19;
  localparam logic [5:0] OP_LDCB  = 6'd20;
  localparam logic [5:0] OP_LDA   = 6'd21;
  localparam logic [5:0] OP_LDB   = 6'd22;
  localparam logic [5:0] OP_STA   = 6'd23;
  localparam logic [5:0] OP_STB   = 6'd24;

  logic        Clock = 1'b0;
  logic        Reset, iValid, iMemValid;
  logic [5:0]  iOpcode;
  logic [8:0]  iAluOut;
  logic [7:0]  iConst, iAddr, iMemData;
  logic        oReady, oCarry, oZero, oMemRead, oMemWrite, oRetire, oError, oState;
  logic [7:0]  oRegA, oRegB, oMemAddr, oMemWData;
  logic [15:0] oRetired;

  acc_writeback #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .iOpcode(iOpcode), .iAluOut(iAluOut), .iConst(iConst), .iAddr(iAddr),
    .iMemData(iMemData), .iMemValid(iMemValid), .oRegA(oRegA), .oRegB(oRegB),
    .oCarry(oCarry), .oZero(oZero), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oRetire(oRetire),
    .oRetired(oRetired), .oError(oError), .oState(oState)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  logic [7:0]  m_a, m_b;
  logic        m_c, m_z, m_err;
  logic [15:0] m_ret;
  int          m_pulses = 0, m_rd = 0;
  int          ret_pulses = 0, rd_pulses = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_c = 1'b0; m_z = 1'b0; m_err = 1'b0; m_ret = 16'h0000;
  endtask

  function automatic void model_retire();
    m_ret = m_ret + 16'd1;
    m_pulses++;
  endfunction

  // Instruction-level semantics for every non-load opcode.
  function automatic void model_exec(input logic [5:0] op, input logic [8:0] alu, input logic [7:0] cst, input logic [7:0] addr);
    case (op)
      OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA, OP_ASLA, OP_ASRA: begin m_a = alu[7:0]; m_c = alu[8]; m_z = (alu[7:0] == 0); end
      OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB:                   begin m_b = alu[7:0]; m_c = alu[8]; m_z = (alu[7:0] == 0); end
      OP_ANDA, OP_ANDCA, OP_ORA, OP_ORCA:                     begin m_a = alu[7:0]; m_z = (alu[7:0] == 0); end
      OP_ANDB, OP_ANDCB, OP_ORB, OP_ORCB:                     begin m_b = alu[7:0]; m_z = (alu[7:0] == 0); end
      OP_LDCA: begin m_a = cst; m_z = (cst == 0); end
      OP_LDCB: begin m_b = cst; m_z = (cst == 0); end
      OP_STA, OP_STB: exp_q.push_back({addr, alu[7:0]});
      default: ;
    endcase
    model_retire();
  endfunction

  always @(negedge Clock) begin
    if (oRetire) ret_pulses++;
    if (oMemRead) rd_pulses++;
    if (oMemWrite) begin
      if (exp_q.size() == 0) check_val("wr_unexpected", 32'd1, 32'd0);
      else check_val("wr_addr_data", {oMemAddr, oMemWData}, exp_q.pop_front());
    end
  end

  task automatic check_arch(input string tag);
    check_val({tag, ".a"},       oRegA,    m_a);
    check_val({tag, ".b"},       oRegB,    m_b);
    check_val({tag, ".carry"},   oCarry,   m_c);
    check_val({tag, ".zero"},    oZero,    m_z);
    check_val({tag, ".err"},     oError,   m_err);
    check_val({tag, ".retired"}, oRetired, m_ret);
    check_val({tag, ".state"},   oState,   1'b0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!oReady && n < 50) begin tick(); n++; end
    if (!oReady) check_val("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [5:0] op, input logic [8:0] alu, input logic [7:0] cst, input logic [7:0] addr);
    wait_ready();
    iValid = 1'b1; iOpcode = op; iAluOut = alu; iConst = cst; iAddr = addr;
    model_exec(op, alu, cst, addr);
    tick();
    iValid = 1'b0;
    check_val("op.retire", oRetire, 1'b1);
    check_val("op.ready",  oReady,  1'b1);
    check_val("op.rd",     oMemRead, 1'b0);
    check_arch("op");
  endtask

  task automatic do_load(input bit is_b, input logic [7:0] addr, input logic [7:0] data, input int lat, input bit respond);
    int cycles = 0;
    int low = 0;
    bit done = 0;
    wait_ready();
    iValid = 1'b1; iOpcode = is_b ? OP_LDB : OP_LDA; iAddr = addr;
    tick();
    m_rd++;
    check_val("ld.rd",    oMemRead, 1'b1);
    check_val("ld.addr",  oMemAddr, addr);
    check_val("ld.state", oState,   1'b1);
    if (!oReady) low++;
    while (!done && cycles < LOAD_TIMEOUT + 4) begin
      iValid    = 1'($urandom_range(0, 1));
      iOpcode   = OP_LDCA;
      iConst    = 8'($urandom);
      iMemValid = respond && (cycles == lat);
      iMemData  = (cycles == lat) ? data : 8'($urandom);
      tick();
      cycles++;
      if (!oReady) low++;
      if (oRetire) done = 1;
    end
    iValid = 1'b0; iMemValid = 1'b0;
    if (respond) begin
      if (is_b) m_b = data; else m_a = data;
      m_z = (data == 0);
    end else begin
      m_err = 1'b1;
    end
    model_retire();
    check_val("ld.retire",  done,   1'b1);
    check_val("ld.latency", cycles, respond ? lat + 1 : LOAD_TIMEOUT);
    check_val("ld.ready_low_cycles", low, respond ? lat + 1 : LOAD_TIMEOUT);
    check_val("ld.ready",   oReady, 1'b1);
    check_arch("ld");
  endtask

  initial begin
    Reset = 1'b1; iValid = 1'b1; iOpcode = OP_LDCA; iConst = 8'h5A;
    iAluOut = 9'h0; iAddr = 8'h0; iMemData = 8'h0; iMemValid = 1'b0;
    model_reset();
    repeat (3) tick();
    check_val("rst.ready", oReady, 1'b0);
    check_arch("rst");
    Reset = 1'b0; iValid = 1'b0;
    tick();
    check_val("rst.ready_after", oReady, 1'b1);
    check_val("rst.dropped_a",   oRegA,  8'h00);

    issue(OP_LDCA, 9'h000, 8'h00, 8'h00);
    issue(OP_LDCB, 9'h000, 8'h7F, 8'h00);
    check_val("ldc.retired2", oRetired, 16'd2);

    issue(OP_ADDA, 9'h100, 8'h00, 8'h00);
    issue(OP_ANDB, 9'h055, 8'h00, 8'h00);

    issue(OP_STB, 9'h0AB, 8'h00, 8'h10);
    tick();
    check_val("st.one_cycle", oMemWrite, 1'b0);

    do_load(1'b0, 8'h20, 8'h3C, 3, 1'b1);
    do_load(1'b1, 8'h21, 8'h00, 0, 1'b1);
    do_load(1'b0, 8'h22, 8'h99, LOAD_TIMEOUT - 1, 1'b1);

    do_load(1'b1, 8'h30, 8'hEE, 0, 1'b0);
    iMemValid = 1'b1; iMemData = 8'hFF;
    repeat (3) begin
      tick();
      check_val("late.retire", oRetire, 1'b0);
    end
    iMemValid = 1'b0;
    check_arch("late");
    issue(OP_NOP, 9'h000, 8'h00, 8'h00);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      op = 6'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) op = ($urandom_range(0, 1) != 0) ? OP_LDA : OP_LDB;
      if (op == OP_LDA || op == OP_LDB)
        do_load(op == OP_LDB, 8'($urandom), 8'($urandom), $urandom_range(0, LOAD_TIMEOUT - 1), $urandom_range(0, 4) != 0);
      else
        issue(op, 9'($urandom), 8'($urandom), 8'($urandom));
    end

    wait_ready();
    iValid = 1'b1; iOpcode = OP_LDA; iAddr = 8'h44;
    tick();
    m_rd++;
    iValid = 1'b0;
    tick();
    Reset = 1'b1; iMemValid = 1'b1; iMemData = 8'h77;
    tick();
    Reset = 1'b0; iMemValid = 1'b0;
    model_reset();
    check_val("rstld.retire", oRetire, 1'b0);
    check_arch("rstld");
    tick();
    check_val("rstld.ready", oReady, 1'b1);
    check_arch("rstld2");

    iValid = 1'b1; iOpcode = OP_NOP;
    repeat (65535) tick();
    iValid = 1'b0;
    m_ret = 16'hFFFF;
    m_pulses += 65535;
    check_val("wrap.ffff", oRetired, 16'hFFFF);
    issue(OP_NOP, 9'h000, 8'h00, 8'h00);
    check_val("wrap.zero", oRetired, 16'h0000);

    repeat (2) tick();
    check_val("sb.pending",     exp_q.size(), 0);
    check_val("sb.retire_cnt",  ret_pulses,   m_pulses);
    check_val("sb.read_cnt",    rd_pulses,    m_rd);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
